// File: rtl/pulse_handshake_rx.sv
// pulse_handshake_rx: destination-side responder of a four-phase req/ack handshake.
// Synchronizes the foreign request level, presents each request as one
// valid/ready event, returns a flop-driven acknowledge level, counts delivered
// events and flags requests retracted before they were accepted.
module pulse_handshake_rx #(
  parameter int unsigned SYNC_STAGE = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  output logic                 ack_a,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CNT_WIDTH-1:0] evt_cnt,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  logic [SYNC_STAGE-1:0] r_sync;
  state_t                r_state;
  logic                  r_ack;
  logic                  r_valid;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_err;

  logic                  w_req_s;
  state_t                w_state_nxt;
  logic                  w_cnt_inc;
  logic                  w_err_set;

  assign w_req_s = r_sync[SYNC_STAGE-1];

  // Synchronizer chain: req_a feeds the first flop with no logic in front of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGE-2:0], req_a};
    end
  end

  // Next-state decode; acceptance wins over a simultaneous request retraction.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_s) begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (evt_ready) begin
          w_state_nxt = ST_ACK;
          w_cnt_inc   = 1'b1;
        end else if (!w_req_s) begin
          w_state_nxt = ST_IDLE;
          w_err_set   = 1'b1;
        end
      end
      ST_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == ST_ACK);
      r_valid <= (w_state_nxt == ST_PEND);
    end
  end

  // Delivered-event counter (wraps) and sticky retraction flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ack_a     = r_ack;
  assign evt_valid = r_valid;
  assign evt_cnt   = r_cnt;
  assign proto_err = r_err;

endmodule

// File: doc/pulse_handshake_rx.md
# pulse_handshake_rx

Destination-side responder of the four-phase req/ack pulse-transfer handshake. Accepts an asynchronous request level from a foreign clock domain, synchronizes it, and presents each request as one valid/ready event to local logic. Returns an acknowledge level that the source domain synchronizes back. Also keeps an event counter and a sticky protocol-error flag.

## Interface
Parameters:
- SYNC_STAGE, 2, number of synchronizer flops on req_a; legal range 2..4.
- CNT_WIDTH, 8, width of the delivered-event counter.

Ports:
- clk  input  1  local clock.
- rst  input  1  synchronous, active-high reset.
- req_a  input  1  request level from the source domain; asynchronous to clk.
- ack_a  output  1  acknowledge level to the source domain; driven directly from a flop.
- evt_valid  output  1  event pending for local consumer.
- evt_ready  input  1  local consumer accepts the event.
- evt_cnt  output  CNT_WIDTH  count of delivered events.
- proto_err  output  1  sticky flag: request retracted before acknowledge.

## Operation
- req_a passes through a SYNC_STAGE-deep flop chain. All flops reset to 0. The last stage is req_s. No logic touches req_a before the first flop.
- FSM states:
  - IDLE: ack_a=0, evt_valid=0.
  - PEND: ack_a=0, evt_valid=1.
  - ACK: ack_a=1, evt_valid=0.
- IDLE -> PEND when req_s=1.
- PEND -> ACK when evt_ready=1. On the same edge, ack_a rises and evt_cnt increments.
- PEND -> IDLE when req_s=0 and evt_ready=0. The event is discarded and proto_err is set.
- PEND with req_s=0 and evt_ready=1 on the same cycle: the handshake is accepted. The FSM goes to ACK, the count increments, and no error is raised.
- ACK -> IDLE when req_s=0. ack_a falls on the same edge.
- While in ACK, req_s staying 1 holds the state. No new event is possible until req_s returns to 0.
- evt_ready is ignored outside PEND.
- evt_cnt wraps modulo 2^CNT_WIDTH. For example, with CNT_WIDTH=8, 255 -> 0.
- proto_err stays set until rst.
- Reset values: state=IDLE, ack_a=0, evt_valid=0, evt_cnt=0, proto_err=0, synchronizer chain=0.
- Reset mid-handshake: rst overrides all transitions, returns the block to IDLE with ack_a=0, and drops any pending event.
  - If req_a is still high after reset, it is treated as a new request once it propagates through the synchronizer.
- All outputs come straight from registers. There is no combinational path from evt_ready to evt_valid or ack_a.

## Timing
- Edges are numbered from the first clk edge that samples req_a=1 (edge 1).
- req_s=1 after edge SYNC_STAGE.
- State=PEND, and therefore evt_valid=1, after edge SYNC_STAGE+1. With SYNC_STAGE=2 that is after edge 3.
- If evt_ready=1 during the first PEND cycle, ack_a=1 and evt_cnt+1 after edge SYNC_STAGE+2.
- Minimum req_a-high-sampled to ack_a-high latency is SYNC_STAGE+2 edges.
- req_a fall: if the first edge sampling req_a=0 is edge k, req_s=0 after edge k+SYNC_STAGE-1.
- ack_a falls after edge k+SYNC_STAGE.
- evt_valid stays high until the acceptance edge or the abort edge. It never drops without one of them.

## Test plan
- Single transfer, SYNC_STAGE=2, evt_ready tied 1: raise req_a before edge 1.
  - Required: evt_valid high for exactly 1 cycle after edge 3, ack_a high after edge 4, evt_cnt=1.
  - Then drop req_a before edge 10. Required: ack_a low after edge 12.
- Back-pressure: evt_ready=0 for 5 cycles after evt_valid rises, then 1.
  - Required: evt_valid held high for 6 cycles, ack_a rises on the edge where evt_ready=1 is sampled, evt_cnt increments once.
- Protocol abort: req_a high, evt_ready=0, req_a dropped while in PEND.
  - Required: evt_valid falls, proto_err=1, evt_cnt unchanged, ack_a never rises.
  - After a subsequent good transfer, proto_err is still 1.
- Simultaneous events: req_s falls on the same cycle evt_ready=1 in PEND.
  - Required: ACK entered, evt_cnt+1, proto_err=0, ack_a low one edge later.
- Counter wrap: CNT_WIDTH=4, 17 complete handshakes. Required: evt_cnt=1, no missed or duplicated events.
- Reset mid-operation: assert rst for 1 cycle while in ACK with req_a still high.
  - Required: ack_a=0 and evt_cnt=0 after the reset edge.
  - Then evt_valid=1 again SYNC_STAGE+1 edges after rst is released.
